// File: rtl/fft_cfg_pkg.sv
// Shared FFT configuration: size limits, mode-code encoding and the per-mode
// derivations (lane, twiddle shift, per-stage offsets) used across the pipeline.
package fft_cfg_pkg;

    localparam int DEF_LOG_MIN = 32'sd5;
    localparam int DEF_LOG_MAX = 32'sd10;

    typedef enum logic [2:0] {
        MODE_32   = 3'd0,
        MODE_64   = 3'd1,
        MODE_128  = 3'd2,
        MODE_256  = 3'd3,
        MODE_512  = 3'd4,
        MODE_1024 = 3'd5
    } fft_mode_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ctrl_state_e;

    function automatic int unsigned tw_shift_of(input int unsigned logn, input int unsigned log_max);
        return log_max - logn;
    endfunction

    // Each radix-2^2 lane consumes two bits of log size.
    function automatic int unsigned lane_of(input int unsigned logn, input int unsigned log_max);
        return tw_shift_of(logn, log_max) >> 32'd1;
    endfunction

    function automatic int unsigned slot_offset(input int unsigned logn, input int unsigned log_max,
                                                input int unsigned slot);
        int unsigned lane;
        int unsigned last_slot;
        lane      = lane_of(logn, log_max);
        last_slot = ((log_max + 32'd1) >> 32'd1) - 32'd1;
        if (slot < lane) begin
            return 32'd0;
        end else if ((slot == last_slot) && (logn[0] == 1'b1)) begin
            return 32'd0;
        end else begin
            return 32'd2 * (slot - lane);
        end
    endfunction

endpackage

// File: rtl/fft_input_ctrl_if.sv
// Sample input and lane/frame output bundle of the FFT input controller.
interface fft_input_ctrl_if
    import fft_cfg_pkg::*;
#(
    parameter int WIDTH   = 32'sd16,
    parameter int LOG_MIN = DEF_LOG_MIN,
    parameter int LOG_MAX = DEF_LOG_MAX
);
    localparam int NMODE = LOG_MAX - LOG_MIN + 32'sd1;
    localparam int MW    = $clog2(NMODE);
    localparam int LANES = (LOG_MAX - LOG_MIN) / 32'sd2 + 32'sd1;
    localparam int NSLOT = (LOG_MAX + 32'sd1) / 32'sd2;
    localparam int SW    = $clog2(LOG_MAX + 32'sd1);

    logic [MW-1:0]          mode_di_sel;
    logic                   abort_di;
    logic                   data_di_en;
    logic [WIDTH-1:0]       data_di_re;
    logic [WIDTH-1:0]       data_di_im;
    logic [LANES-1:0]       lane_do_en;
    logic [LANES*WIDTH-1:0] lane_do_re;
    logic [LANES*WIDTH-1:0] lane_do_im;
    logic                   sop_do;
    logic                   eop_do;
    logic [LOG_MAX-1:0]     idx_do;
    logic [NMODE-1:0]       sel_do;
    logic [MW-1:0]          mode_do_sel;
    logic [LOG_MAX-1:0]     cnt_do_max;
    logic [SW-1:0]          tw_addr_shift_do;
    logic [NSLOT*SW-1:0]    logn_minus_logm_do;
    logic                   busy_do;
    logic                   mode_err_do;

    modport master (
        output mode_di_sel, abort_di, data_di_en, data_di_re, data_di_im,
        input  lane_do_en, lane_do_re, lane_do_im, sop_do, eop_do, idx_do, sel_do,
               mode_do_sel, cnt_do_max, tw_addr_shift_do, logn_minus_logm_do,
               busy_do, mode_err_do
    );

    modport slave (
        input  mode_di_sel, abort_di, data_di_en, data_di_re, data_di_im,
        output lane_do_en, lane_do_re, lane_do_im, sop_do, eop_do, idx_do, sel_do,
               mode_do_sel, cnt_do_max, tw_addr_shift_do, logn_minus_logm_do,
               busy_do, mode_err_do
    );

endinterface

// File: rtl/fft_mode_decode.sv
// Combinational mode decoder: code -> lane, counter max, twiddle shift,
// per-stage offsets, one-hot select and an out-of-range flag.
module fft_mode_decode
    import fft_cfg_pkg::*;
#(
    parameter int  LOG_MIN = DEF_LOG_MIN,
    parameter int  LOG_MAX = DEF_LOG_MAX,
    localparam int NMODE   = LOG_MAX - LOG_MIN + 32'sd1,
    localparam int MW      = $clog2(NMODE),
    localparam int LANES   = (LOG_MAX - LOG_MIN) / 32'sd2 + 32'sd1,
    localparam int LW      = (LANES > 32'sd1) ? $clog2(LANES) : 32'sd1,
    localparam int NSLOT   = (LOG_MAX + 32'sd1) / 32'sd2,
    localparam int SW      = $clog2(LOG_MAX + 32'sd1)
) (
    input  logic [MW-1:0]       code,
    output logic [MW-1:0]       code_eff,
    output logic [NMODE-1:0]    sel,
    output logic [LW-1:0]       lane,
    output logic [LOG_MAX-1:0]  cnt_max,
    output logic [SW-1:0]       tw_shift,
    output logic [NSLOT*SW-1:0] offsets,
    output logic                invalid
);

    int unsigned logn_s;

    // Out-of-range codes fold onto the largest supported size.
    always_comb begin
        if (32'(code) >= NMODE) begin
            invalid  = 1'b1;
            code_eff = MW'(NMODE - 32'sd1);
        end else begin
            invalid  = 1'b0;
            code_eff = code;
        end
        logn_s   = LOG_MIN + 32'(code_eff);
        lane     = LW'(lane_of(logn_s, LOG_MAX));
        tw_shift = SW'(tw_shift_of(logn_s, LOG_MAX));
        cnt_max  = {LOG_MAX{1'b1}} >> tw_shift;
        sel           = '0;
        sel[code_eff] = 1'b1;
        offsets  = '0;
        for (int unsigned s = 32'd0; s < NSLOT; s++) begin
            offsets[s*SW +: SW] = SW'(slot_offset(logn_s, LOG_MAX, s));
        end
    end

endmodule

// File: rtl/fft_input_ctrl.sv
// FFT front end: latches the point-size mode at frame start, tracks frame
// position and steers each sample onto the lane where that size enters.
module fft_input_ctrl
    import fft_cfg_pkg::*;
#(
    parameter int WIDTH   = 32'sd16,
    parameter int LOG_MIN = DEF_LOG_MIN,
    parameter int LOG_MAX = DEF_LOG_MAX
) (
    input  logic            clock,
    input  logic            reset,
    fft_input_ctrl_if.slave bus
);

    localparam int NMODE = LOG_MAX - LOG_MIN + 32'sd1;
    localparam int MW    = $clog2(NMODE);
    localparam int LANES = (LOG_MAX - LOG_MIN) / 32'sd2 + 32'sd1;
    localparam int LW    = (LANES > 32'sd1) ? $clog2(LANES) : 32'sd1;
    localparam int NSLOT = (LOG_MAX + 32'sd1) / 32'sd2;
    localparam int SW    = $clog2(LOG_MAX + 32'sd1);
    localparam logic [LOG_MAX-1:0] IDX_ONE = LOG_MAX'(32'd1);

    ctrl_state_e            state_r, state_s;
    logic [LOG_MAX-1:0]     idx_r, idx_s;
    logic [MW-1:0]          code_raw_r, code_raw_s;
    logic [MW-1:0]          code_seen_r, code_seen_s;
    logic [LW-1:0]          lane_r, lane_s;
    logic [MW-1:0]          mode_r, mode_s;
    logic [NMODE-1:0]       sel_r, sel_s;
    logic [LOG_MAX-1:0]     cnt_max_r, cnt_max_s;
    logic [SW-1:0]          tw_r, tw_s;
    logic [NSLOT*SW-1:0]    off_r, off_s;
    logic [LANES-1:0]       lane_en_r, lane_en_s;
    logic [LANES*WIDTH-1:0] lane_re_r, lane_re_s;
    logic [LANES*WIDTH-1:0] lane_im_r, lane_im_s;
    logic                   sop_r, sop_s, eop_r, eop_s;
    logic                   err_r, err_s, busy_r, busy_s;
    logic                   take_s;

    logic [MW-1:0]          dec_code_s;
    logic [NMODE-1:0]       dec_sel_s;
    logic [LW-1:0]          dec_lane_s;
    logic [LOG_MAX-1:0]     dec_cnt_max_s;
    logic [SW-1:0]          dec_tw_s;
    logic [NSLOT*SW-1:0]    dec_off_s;
    logic                   dec_invalid_s;

    fft_mode_decode #(
        .LOG_MIN (LOG_MIN),
        .LOG_MAX (LOG_MAX)
    ) u_decode (
        .code     (bus.mode_di_sel),
        .code_eff (dec_code_s),
        .sel      (dec_sel_s),
        .lane     (dec_lane_s),
        .cnt_max  (dec_cnt_max_s),
        .tw_shift (dec_tw_s),
        .offsets  (dec_off_s),
        .invalid  (dec_invalid_s)
    );

    // Frame control: start, advance, end, abort; configuration only loads at frame start.
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        code_raw_s  = code_raw_r;
        code_seen_s = code_seen_r;
        lane_s      = lane_r;
        mode_s      = mode_r;
        sel_s       = sel_r;
        cnt_max_s   = cnt_max_r;
        tw_s        = tw_r;
        off_s       = off_r;
        take_s      = 1'b0;
        sop_s       = 1'b0;
        eop_s       = 1'b0;
        err_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.data_di_en && !bus.abort_di) begin
                    take_s      = 1'b1;
                    sop_s       = 1'b1;
                    err_s       = dec_invalid_s;
                    idx_s       = '0;
                    code_raw_s  = bus.mode_di_sel;
                    code_seen_s = bus.mode_di_sel;
                    lane_s      = dec_lane_s;
                    mode_s      = dec_code_s;
                    sel_s       = dec_sel_s;
                    cnt_max_s   = dec_cnt_max_s;
                    tw_s        = dec_tw_s;
                    off_s       = dec_off_s;
                    if (dec_cnt_max_s == '0) begin
                        eop_s   = 1'b1;
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.abort_di) begin
                    state_s = ST_IDLE;
                    idx_s   = '0;
                end else if (bus.data_di_en) begin
                    take_s      = 1'b1;
                    idx_s       = idx_r + IDX_ONE;
                    code_seen_s = bus.mode_di_sel;
                    // A held mismatching code is one event, so only a newly seen value pulses.
                    err_s = (bus.mode_di_sel != code_raw_r) && (bus.mode_di_sel != code_seen_r);
                    if (idx_s == cnt_max_r) begin
                        eop_s   = 1'b1;
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: begin
                state_s = ST_IDLE;
                idx_s   = '0;
            end
        endcase
        busy_s = (state_s == ST_RUN);
    end

    // Steer the accepted sample onto its lane; every other lane stays zero.
    always_comb begin
        lane_en_s = '0;
        lane_re_s = '0;
        lane_im_s = '0;
        for (int k = 32'sd0; k < LANES; k++) begin
            if (take_s && (LW'(k) == lane_s)) begin
                lane_en_s[k]               = 1'b1;
                lane_re_s[k*WIDTH +: WIDTH] = bus.data_di_re;
                lane_im_s[k*WIDTH +: WIDTH] = bus.data_di_im;
            end else begin
                lane_en_s[k] = 1'b0;
            end
        end
    end

    // FSM state, frame index and the codes seen during the frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            idx_r       <= '0;
            code_raw_r  <= '0;
            code_seen_r <= '0;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            code_raw_r  <= code_raw_s;
            code_seen_r <= code_seen_s;
        end
    end

    // Registered outputs and the per-frame configuration.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lane_r    <= '0;
            mode_r    <= '0;
            sel_r     <= '0;
            cnt_max_r <= '0;
            tw_r      <= '0;
            off_r     <= '0;
            lane_en_r <= '0;
            lane_re_r <= '0;
            lane_im_r <= '0;
            sop_r     <= 1'b0;
            eop_r     <= 1'b0;
            err_r     <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            lane_r    <= lane_s;
            mode_r    <= mode_s;
            sel_r     <= sel_s;
            cnt_max_r <= cnt_max_s;
            tw_r      <= tw_s;
            off_r     <= off_s;
            lane_en_r <= lane_en_s;
            lane_re_r <= lane_re_s;
            lane_im_r <= lane_im_s;
            sop_r     <= sop_s;
            eop_r     <= eop_s;
            err_r     <= err_s;
            busy_r    <= busy_s;
        end
    end

    assign bus.lane_do_en         = lane_en_r;
    assign bus.lane_do_re         = lane_re_r;
    assign bus.lane_do_im         = lane_im_r;
    assign bus.sop_do             = sop_r;
    assign bus.eop_do             = eop_r;
    assign bus.idx_do             = idx_r;
    assign bus.sel_do             = sel_r;
    assign bus.mode_do_sel        = mode_r;
    assign bus.cnt_do_max         = cnt_max_r;
    assign bus.tw_addr_shift_do   = tw_r;
    assign bus.logn_minus_logm_do = off_r;
    assign bus.busy_do            = busy_r;
    assign bus.mode_err_do        = err_r;

endmodule

// File: tb/tb_fft_input_ctrl.sv
// Scoreboard bench for fft_input_ctrl: stimulus pushes expected lane outputs,
// a negedge monitor pops and compares whenever a lane is valid.
module tb_fft_input_ctrl;
    import fft_cfg_pkg::*;

    localparam int WIDTH   = 16;
    localparam int LOG_MIN = 5;
    localparam int LOG_MAX = 10;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    fft_input_ctrl_if #(.WIDTH(WIDTH), .LOG_MIN(LOG_MIN), .LOG_MAX(LOG_MAX)) bus ();

    fft_input_ctrl #(.WIDTH(WIDTH), .LOG_MIN(LOG_MIN), .LOG_MAX(LOG_MAX)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0]  en;
        logic [47:0] re;
        logic [47:0] im;
        logic        sop, eop, err, busy;
        logic [9:0]  idx;
        logic [9:0]  cnt;
        logic [3:0]  tw;
        logic [19:0] off;
        logic [5:0]  sel;
        logic [2:0]  mode;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;

    // Hand-computed per-mode tables, indexed by effective code (32 .. 1024 points).
    logic [19:0] off_tbl [6] = '{20'h02000, 20'h42000, 20'h04200, 20'h64200, 20'h06420, 20'h86420};
    int          lane_tbl[6] = '{2, 2, 1, 1, 0, 0};

    bit         m_run  = 1'b0;
    int         m_eff  = 0;
    logic [2:0] m_raw  = 3'd0;
    logic [2:0] m_seen = 3'd0;
    int         m_idx  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [15:0] re, input logic [15:0] im,
                            input bit sop, input bit eop, input bit err);
        exp_t e;
        int   ln;
        ln     = lane_tbl[m_eff];
        e.en   = 3'(32'd1 << ln);
        e.re   = 48'(re) << (16 * ln);
        e.im   = 48'(im) << (16 * ln);
        e.sop  = sop;
        e.eop  = eop;
        e.err  = err;
        e.busy = m_run;
        e.idx  = 10'(m_idx);
        e.cnt  = 10'((32'd1 << (LOG_MIN + m_eff)) - 32'd1);
        e.tw   = 4'(LOG_MAX - LOG_MIN - m_eff);
        e.off  = off_tbl[m_eff];
        e.sel  = 6'(32'd1 << m_eff);
        e.mode = 3'(m_eff);
        sb_q.push_back(e);
    endtask

    task automatic cycle(input bit en, input bit ab, input logic [2:0] code,
                         input logic [15:0] re, input logic [15:0] im);
        bit eop, err;
        bus.data_di_en  = en;
        bus.abort_di    = ab;
        bus.mode_di_sel = code;
        bus.data_di_re  = re;
        bus.data_di_im  = im;
        if (!m_run) begin
            if (en && !ab) begin
                m_eff  = (code > 3'd5) ? 5 : int'(code);
                m_raw  = code;
                m_seen = code;
                m_idx  = 0;
                m_run  = 1'b1;
                push_exp(re, im, 1'b1, 1'b0, code > 3'd5);
            end
        end else if (ab) begin
            m_run = 1'b0;
            m_idx = 0;
        end else if (en) begin
            m_idx++;
            err    = (code != m_raw) && (code != m_seen);
            m_seen = code;
            eop    = (m_idx == (1 << (LOG_MIN + m_eff)) - 1);
            if (eop) m_run = 1'b0;
            push_exp(re, im, 1'b0, eop, err);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_lane_en"}, 64'(bus.lane_do_en), 64'd0);
        chk({tag, "_lane_re"}, 64'(bus.lane_do_re), 64'd0);
        chk({tag, "_lane_im"}, 64'(bus.lane_do_im), 64'd0);
        chk({tag, "_flags"}, 64'({bus.sop_do, bus.eop_do, bus.mode_err_do, bus.busy_do}), 64'd0);
        chk({tag, "_idx"}, 64'(bus.idx_do), 64'd0);
        chk({tag, "_cfg"}, 64'({bus.cnt_do_max, bus.tw_addr_shift_do, bus.logn_minus_logm_do,
                               bus.sel_do, bus.mode_do_sel}), 64'd0);
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (bus.lane_do_en != 3'b000) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_sample", 64'(bus.lane_do_en), 64'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("lane_en", 64'(bus.lane_do_en), 64'(mon_e.en));
                    chk("lane_re", 64'(bus.lane_do_re), 64'(mon_e.re));
                    chk("lane_im", 64'(bus.lane_do_im), 64'(mon_e.im));
                    chk("sop_eop_err_busy", 64'({bus.sop_do, bus.eop_do, bus.mode_err_do, bus.busy_do}),
                        64'({mon_e.sop, mon_e.eop, mon_e.err, mon_e.busy}));
                    chk("idx", 64'(bus.idx_do), 64'(mon_e.idx));
                    chk("cfg", 64'({bus.cnt_do_max, bus.tw_addr_shift_do, bus.logn_minus_logm_do,
                                   bus.sel_do, bus.mode_do_sel}),
                        64'({mon_e.cnt, mon_e.tw, mon_e.off, mon_e.sel, mon_e.mode}));
                end
            end else begin
                chk("idle_flags", 64'({bus.sop_do, bus.eop_do, bus.mode_err_do}), 64'd0);
                chk("idle_lane_data", 64'(bus.lane_do_re | bus.lane_do_im), 64'd0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.data_di_en  = 1'b0;
        bus.abort_di    = 1'b0;
        bus.mode_di_sel = 3'd0;
        bus.data_di_re  = 16'd0;
        bus.data_di_im  = 16'd0;
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        cycle(1'b0, 1'b0, MODE_32, 16'd0, 16'd0);

        // 1024-point frame, continuous
        for (int i = 0; i < 1024; i++) cycle(1'b1, 1'b0, MODE_1024, 16'(i * 3 + 1), 16'(16'hFFFF - i));
        repeat (2) cycle(1'b0, 1'b0, MODE_1024, 16'd0, 16'd0);
        chk("busy_after_1024", 64'(bus.busy_do), 64'd0);

        // Back-to-back 32 then 128
        for (int i = 0; i < 32; i++) cycle(1'b1, 1'b0, MODE_32, 16'(16'h2000 + i), 16'(16'h3000 + i));
        for (int i = 0; i < 128; i++) cycle(1'b1, 1'b0, MODE_128, 16'(16'h4000 + i), 16'(16'h5000 + i));
        repeat (2) cycle(1'b0, 1'b0, MODE_128, 16'd0, 16'd0);

        // Mode switch 0 -> 3 at idx 10 of a 32-point frame
        for (int i = 0; i < 32; i++)
            cycle(1'b1, 1'b0, (i >= 10) ? MODE_256 : MODE_32, 16'(16'h6000 + i), 16'(16'h7000 + i));
        cycle(1'b0, 1'b0, MODE_32, 16'd0, 16'd0);

        // Abort in IDLE is a no-op and drops the sample
        cycle(1'b1, 1'b1, MODE_32, 16'hDEAD, 16'hBEEF);
        cycle(1'b0, 1'b0, MODE_32, 16'd0, 16'd0);
        chk("idle_abort_busy", 64'(bus.busy_do), 64'd0);

        // Abort at idx 100 of a 256-point frame, then a full frame
        for (int i = 0; i < 100; i++) cycle(1'b1, 1'b0, MODE_256, 16'(16'h8000 + i), 16'(i));
        cycle(1'b1, 1'b1, MODE_256, 16'hAAAA, 16'h5555);
        chk("abort_busy", 64'(bus.busy_do), 64'd0);
        for (int i = 0; i < 256; i++) cycle(1'b1, 1'b0, MODE_256, 16'(16'h9000 + i), 16'(16'h1000 + i));
        cycle(1'b0, 1'b0, MODE_256, 16'd0, 16'd0);

        // Out-of-range code at frame start behaves as 1024 points
        for (int i = 0; i < 1024; i++) cycle(1'b1, 1'b0, 3'd7, 16'(16'hC000 + i), 16'(i * 5));
        cycle(1'b0, 1'b0, 3'd7, 16'd0, 16'd0);

        // Gappy 64-point frame, reset after idx 40
        for (int i = 0; i <= 40; i++) begin
            cycle(1'b1, 1'b0, MODE_64, 16'(16'hE000 + i), 16'(16'h0F00 + i));
            cycle(1'b0, 1'b0, MODE_64, 16'd0, 16'd0);
            cycle(1'b0, 1'b0, MODE_64, 16'd0, 16'd0);
        end
        chk("idx_before_reset", 64'(bus.idx_do), 64'd40);
        chk("sb_drained_before_reset", 64'(sb_q.size()), 64'd0);
        reset = 1'b1;
        m_run = 1'b0;
        m_idx = 0;
        #1;
        check_all_zero("mid_reset");
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 64; i++) cycle(1'b1, 1'b0, MODE_64, 16'(16'hF000 + i), 16'(16'h0A00 + i));
        repeat (3) cycle(1'b0, 1'b0, MODE_64, 16'd0, 16'd0);

        chk("sb_empty_at_end", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_input_ctrl.md
# fft_input_ctrl

Parametrised front end for the multi-mode radix-2² pipelined FFT. It decodes the point-size mode, latches it at frame start, and routes each input sample to the pipeline lane where that size enters. It also tracks frame position (index, start, end) and holds all per-frame configuration (counter max, twiddle shift, per-stage log offsets) stable for the whole frame. Mode changes in mid-frame and abort requests are handled explicitly.

## Interface
Parameters:
- WIDTH, 16, sample width per real/imag component
- LOG_MIN, 5, log2 of smallest FFT size
- LOG_MAX, 10, log2 of largest FFT size
- derived: NMODE = LOG_MAX-LOG_MIN+1; MW = clog2(NMODE); LANES = (LOG_MAX-LOG_MIN)/2+1; NSLOT = ceil(LOG_MAX/2); SW = clog2(LOG_MAX+1)

Ports:
- clock  in  1  master clock
- reset  in  1  Active High Asynchronous Reset
- mode_di_sel  in  MW  mode code; logn = LOG_MIN + code
- abort_di  in  1  synchronous frame abort
- data_di_en  in  1  input sample valid
- data_di_re / data_di_im  in  WIDTH  input sample
- lane_do_en  out  LANES  one-hot lane valid
- lane_do_re / lane_do_im  out  LANES*WIDTH  lane data; lane k at bits [k*WIDTH +: WIDTH]
- sop_do / eop_do  out  1  first / last sample of frame
- idx_do  out  LOG_MAX  sample index within frame
- sel_do  out  NMODE  one-hot latched mode
- mode_do_sel  out  MW  latched mode code
- cnt_do_max  out  LOG_MAX  2^logn − 1
- tw_addr_shift_do  out  SW  LOG_MAX − logn
- logn_minus_logm_do  out  NSLOT*SW  per-stage offsets, slot s at [s*SW +: SW]
- busy_do  out  1  frame in progress
- mode_err_do  out  1  one-cycle error pulse

## Operation
- FSM has two states, IDLE and RUN. Reset state is IDLE.
- **IDLE:**
  - On data_di_en with abort_di low, this cycle is the frame start.
  - Latch the mode. A code ≥ NMODE is treated as LOG_MAX and raises mode_err_do.
  - Load the configuration registers, emit the sample with sop, set idx = 0, go to RUN.
  - Exception: if cnt_max = 0, the sample also carries eop and the FSM stays in IDLE.
- **RUN:**
  - Each data_di_en advances idx by 1.
  - The sample with idx == cnt_max carries eop; the FSM returns to IDLE.
  - Back-to-back frames are allowed: the next valid sample starts a new frame and samples mode_di_sel then.
  - Cycles with data_di_en low produce no output and hold state.
- **Mode change mid-frame:** if mode_di_sel ≠ latched code while in RUN and data_di_en is high, the change is ignored and mode_err_do pulses. The latched configuration is never altered in RUN.
- **Abort:** abort_di has the highest priority. The FSM goes to IDLE and idx clears. Any sample presented in the same cycle is dropped (no lane_do_en, no eop). In IDLE, abort is a no-op.
- **Lane selection:** lane = (LOG_MAX − logn) >> 1. Only that lane's data carries the sample; all other lanes, and all lanes on non-valid cycles, output zero.
- **Per-stage offsets:** for slot s:
  - s < lane: value is 0.
  - s ≥ lane: value is 2·(s − lane).
  - Exception: slot NSLOT−1 is 0 when logn is odd.
  - Defaults give: 1024 → 0,2,4,6,8; 512 → 0,2,4,6,0; 32 → 0,0,0,2,0.

## Timing
- All outputs are registered; latency from input to output is 1 cycle.
- Configuration outputs change only on the edge that registers a frame-start sample, so they align with sop_do.
- Reset values of all outputs are 0, including sel_do, lane data, the configuration fields and the flags.
- Reset asserted mid-frame drops the frame immediately; the next valid sample after reset is a frame start.
- idx never exceeds cnt_max. Wrap-around is to 0 via IDLE, never by counter overflow.
- mode_err_do, sop_do and eop_do are each high for exactly one cycle per event.

## Structure
- Shared package fft_cfg_pkg holds:
  - LOG_MIN and LOG_MAX defaults and the mode-code encoding
  - a function for lane index
  - a function for the per-slot offset
  - a function for tw shift
  - These are reused by the stage and twiddle blocks.
- One combinational sub-module, fft_mode_decode: maps a code to logn, lane, cnt_max, tw shift, offsets and the invalid flag. The top level contains the FSM, the index counter and the output registers.

## Test plan
- **Mode 5 (1024), 1024 continuous samples:** lane 0 only; sop at idx 0; eop at idx 1023; tw shift 0; offsets 0,2,4,6,8; busy_do drops after eop.
- **Back-to-back frames, code 0 then code 2 (32 then 128):**
  - Frame 1 is on lane 2 with cnt_do_max 31.
  - Frame 2 starts the cycle after eop, on lane 1, with cnt_do_max 127 and offsets 0,0,2,4,0.
- **Mode switched 0 → 3 at idx 10 of a 32-point frame:** mode_err_do pulses once; configuration stays 32-point; eop occurs at idx 31.
- **abort_di together with a valid sample at idx 100 of a 256-point frame:**
  - That sample is not output.
  - The next valid sample carries sop with idx 0.
- **Code 7 at frame start:** mode_err_do pulses; behaviour is 1024-point (cnt_do_max 1023, lane 0).
- **Gappy data_di_en (1 of 3 cycles) and reset at idx 40:**
  - Gaps do not affect idx.
  - After reset all outputs read 0 and the next sample carries sop.
